// File: rtl/span_scheduler.sv
// span_scheduler
// Merges span records from two CalcLine producers (A, B) into a small
// circular FIFO using round-robin arbitration. Spans are handed to drawline
// one at a time over the span_start/span_done handshake. A frame flush
// stops intake, lets every queued span issue, waits out drawline's write
// pipeline and then raises flush_ack so the frame buffer can be swapped.
//
// Ports
//   clk, rst              clock, asynchronous active-high reset
//   a_data/a_valid/a_ready  producer A intake (transfer on valid && ready)
//   b_data/b_valid/b_ready  producer B intake
//   span_data, span_start   registered span record and one-cycle issue pulse
//   span_done               drawline idle/ready
//   flush_req, flush_ack    end-of-frame drain handshake (level based)
//   fifo_count              current FIFO occupancy
//   busy                    FIFO non-empty or FSM not idle
//
// state   | meaning
// IDLE    | nothing in flight; issue as soon as a span is queued
// START   | span_start pulse is out; drawline samples it on this edge
// BUSY    | drawline working; wait for span_done
// DRAIN   | FIFO empty, drawline idle; counting out its write pipeline
// FLUSHED | frame drained, flush_ack high until flush_req drops
module span_scheduler #(
    parameter int DEPTH        = 4,
    parameter int DRAIN_CYCLES = 4,
    parameter int W            = 249
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [W-1:0]             a_data,
    input  logic                     a_valid,
    output logic                     a_ready,
    input  logic [W-1:0]             b_data,
    input  logic                     b_valid,
    output logic                     b_ready,
    output logic [W-1:0]             span_data,
    output logic                     span_start,
    input  logic                     span_done,
    input  logic                     flush_req,
    output logic                     flush_ack,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     busy
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C    = CW'(DEPTH);
    localparam logic [15:0]   DRAIN_LOAD = 16'(DRAIN_CYCLES);

    typedef enum logic [2:0] {IDLE, START, BUSY, DRAIN, FLUSHED} state_t;

    state_t         state;
    logic [W-1:0]   mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic           rr_last_b;   // 1: B won the last transfer, so A is favoured
    logic [15:0]    drain_cnt;

    logic           fifo_empty;
    logic           fifo_full;
    logic           accept_ok;
    logic           grant_a;
    logic           grant_b;
    logic           push;
    logic           pop;
    logic [W-1:0]   push_data;

    assign fifo_empty = (fifo_count == '0);
    // Readies look only at the current count, so a full FIFO refuses intake
    // even when a pop happens on the same edge.
    assign fifo_full  = (fifo_count == DEPTH_C);
    assign accept_ok  = !fifo_full && !flush_req && (state != DRAIN) && (state != FLUSHED);

    assign grant_a = a_valid && (!b_valid || rr_last_b);
    assign grant_b = b_valid && (!a_valid || !rr_last_b);
    assign a_ready = accept_ok && grant_a;
    assign b_ready = accept_ok && grant_b;

    assign push      = a_ready || b_ready;
    assign push_data = a_ready ? a_data : b_data;

    // Issue happens from IDLE or at the end of BUSY, identically in both.
    assign pop = !fifo_empty && span_done && ((state == IDLE) || (state == BUSY));

    assign busy = !fifo_empty || (state != IDLE);

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            span_start <= 1'b0;
            flush_ack  <= 1'b0;
            span_data  <= '0;
            fifo_count <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            rr_last_b  <= 1'b1;
            drain_cnt  <= '0;
        end else begin
            span_start <= 1'b0;

            if (push) begin
                wr_ptr    <= wr_ptr + AW'(1);
                rr_last_b <= b_ready;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CW'(1);
                2'b01:   fifo_count <= fifo_count - CW'(1);
                default: fifo_count <= fifo_count;
            endcase

            case (state)
                IDLE: begin
                    if (pop) begin
                        span_data  <= mem[rd_ptr];
                        span_start <= 1'b1;
                        state      <= START;
                    end else if (flush_req && fifo_empty && span_done) begin
                        drain_cnt <= DRAIN_LOAD;
                        state     <= DRAIN;
                    end
                end
                // span_done is ignored here: drawline drops it on this edge.
                START: state <= BUSY;
                BUSY: begin
                    if (span_done) begin
                        if (pop) begin
                            span_data  <= mem[rd_ptr];
                            span_start <= 1'b1;
                            state      <= START;
                        end else if (flush_req) begin
                            drain_cnt <= DRAIN_LOAD;
                            state     <= DRAIN;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                // The cycle in which span_done is seen counts as the first
                // drain cycle, so the ack lands on the edge where the counter
                // reaches 1.
                DRAIN: begin
                    if (!flush_req) begin
                        state <= IDLE;
                    end else if (drain_cnt <= 16'd2) begin
                        drain_cnt <= 16'd1;
                        flush_ack <= 1'b1;
                        state     <= FLUSHED;
                    end else begin
                        drain_cnt <= drain_cnt - 16'd1;
                    end
                end
                FLUSHED: begin
                    if (!flush_req) begin
                        flush_ack <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_span_scheduler.sv
// tb_span_scheduler
// Directed bench for span_scheduler with a small drawline model that drops
// span_done on the edge it sees span_start and raises it dl_lat cycles later.
module tb_span_scheduler;

    localparam int W     = 249;
    localparam int DEPTH = 4;
    localparam int DRAIN = 4;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [W-1:0]   a_data = '0;
    logic           a_valid = 1'b0;
    logic           a_ready;
    logic [W-1:0]   b_data = '0;
    logic           b_valid = 1'b0;
    logic           b_ready;
    logic [W-1:0]   span_data;
    logic           span_start;
    logic           span_done;
    logic           flush_req = 1'b0;
    logic           flush_ack;
    logic [2:0]     fifo_count;
    logic           busy;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    // drawline model
    logic dl_done;
    logic dl_hold = 1'b0;
    int   dl_cnt;
    int   dl_lat = 5;

    // issue monitor
    logic [W-1:0] issued_q [$];
    logic done_q  = 1'b1;
    logic start_q = 1'b0;
    int   rise_cyc = 0;
    logic chk_gap = 1'b0;

    span_scheduler #(.DEPTH(DEPTH), .DRAIN_CYCLES(DRAIN), .W(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .a_data     (a_data),
        .a_valid    (a_valid),
        .a_ready    (a_ready),
        .b_data     (b_data),
        .b_valid    (b_valid),
        .b_ready    (b_ready),
        .span_data  (span_data),
        .span_start (span_start),
        .span_done  (span_done),
        .flush_req  (flush_req),
        .flush_ack  (flush_ack),
        .fifo_count (fifo_count),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    assign span_done = dl_done & ~dl_hold;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            dl_done <= 1'b1;
            dl_cnt  <= 0;
        end else if (span_start) begin
            dl_done <= 1'b0;
            dl_cnt  <= dl_lat;
        end else if (!dl_done) begin
            if (dl_cnt <= 1) dl_done <= 1'b1;
            else             dl_cnt  <= dl_cnt - 1;
        end
    end

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            done_q  = 1'b1;
            start_q = 1'b0;
        end else begin
            if (span_done && !done_q) rise_cyc = cyc;
            if (span_start) begin
                check("start_single", 256'(start_q), 256'(0));
                if (chk_gap) check("start_gap", 256'(cyc - rise_cyc), 256'(1));
                issued_q.push_back(span_data);
            end
            done_q  = span_done;
            start_q = span_start;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        a_valid = 1'b0;
        b_valid = 1'b0;
        flush_req = 1'b0;
        dl_hold = 1'b0;
        chk_gap = 1'b0;
        repeat (2) tick();
        rst = 1'b0;
        issued_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int ack_cyc;
        logic seen;
        logic exp_a;
        logic [W-1:0] exp_q [$];

        // ---------------- reset state
        rst = 1'b1;
        tick();
        check("rst_span_start", 256'(span_start), 256'(0));
        check("rst_flush_ack",  256'(flush_ack),  256'(0));
        check("rst_span_data",  256'(span_data),  256'(0));
        check("rst_fifo_count", 256'(fifo_count), 256'(0));
        check("rst_busy",       256'(busy),       256'(0));

        // ---------------- single span
        do_reset();
        dl_lat = 5;
        a_data = W'(12'h1A5);
        a_valid = 1'b1;
        settle();
        check("single_a_ready", 256'(a_ready), 256'(1));
        check("single_b_ready", 256'(b_ready), 256'(0));
        tick();                                   // E0: push
        a_valid = 1'b0;
        check("single_cnt_e0",   256'(fifo_count), 256'(1));
        check("single_start_e0", 256'(span_start), 256'(0));
        check("single_busy_e0",  256'(busy),       256'(1));
        tick();                                   // E1: issue
        check("single_start_e1", 256'(span_start), 256'(1));
        check("single_data_e1",  256'(span_data),  256'(12'h1A5));
        check("single_cnt_e1",   256'(fifo_count), 256'(0));
        tick();                                   // E2
        check("single_start_e2", 256'(span_start), 256'(0));
        check("single_data_e2",  256'(span_data),  256'(12'h1A5));
        for (int i = 0; i < 5; i++) begin         // E3..E7, drawline busy
            tick();
            check("single_no_pulse", 256'(span_start), 256'(0));
        end
        check("single_data_e7", 256'(span_data), 256'(12'h1A5));
        tick();                                   // E8: back to IDLE
        check("single_idle_busy", 256'(busy), 256'(0));
        check("single_issued", 256'(issued_q.size()), 256'(1));

        // ---------------- round robin, A first after reset
        do_reset();
        dl_hold = 1'b1;
        a_valid = 1'b1;
        b_valid = 1'b1;
        a_data = W'(12'hA00);
        b_data = W'(12'hB00);
        for (int i = 0; i < 4; i++) begin
            exp_a = (i % 2 == 0);
            settle();
            check("rr_a_ready", 256'(a_ready), 256'(exp_a));
            check("rr_b_ready", 256'(b_ready), 256'(!exp_a));
            tick();
            if (exp_a) a_data = a_data + W'(1);
            else       b_data = b_data + W'(1);
        end
        check("rr_full_cnt", 256'(fifo_count), 256'(4));
        settle();
        check("rr_full_a_ready", 256'(a_ready), 256'(0));
        check("rr_full_b_ready", 256'(b_ready), 256'(0));
        tick();
        check("rr_full_cnt2", 256'(fifo_count), 256'(4));
        a_valid = 1'b0;
        b_valid = 1'b0;
        dl_lat = 2;
        dl_hold = 1'b0;
        for (int t = 0; t < 100 && issued_q.size() < 4; t++) tick();
        exp_q = '{W'(12'hA00), W'(12'hB00), W'(12'hA01), W'(12'hB01)};
        check("rr_issue_count", 256'(issued_q.size()), 256'(4));
        for (int i = 0; i < 4 && i < issued_q.size(); i++)
            check("rr_order", 256'(issued_q[i]), 256'(exp_q[i]));

        // ---------------- back-to-back issue
        do_reset();
        dl_hold = 1'b1;
        dl_lat = 5;
        a_valid = 1'b1;
        a_data = W'(12'h300);
        for (int i = 0; i < 3; i++) begin
            tick();
            a_data = a_data + W'(1);
        end
        a_valid = 1'b0;
        check("b2b_cnt", 256'(fifo_count), 256'(3));
        chk_gap = 1'b1;
        dl_hold = 1'b0;
        for (int t = 0; t < 200 && issued_q.size() < 3; t++) tick();
        for (int t = 0; t < 200 && busy; t++) tick();
        repeat (3) tick();
        chk_gap = 1'b0;
        check("b2b_idle", 256'(busy), 256'(0));
        check("b2b_issue_count", 256'(issued_q.size()), 256'(3));
        for (int i = 0; i < 3 && i < issued_q.size(); i++)
            check("b2b_order", 256'(issued_q[i]), 256'(12'h300 + i));

        // ---------------- flush with two queued spans
        do_reset();
        dl_hold = 1'b1;
        dl_lat = 3;
        a_valid = 1'b1;
        a_data = W'(12'h401);
        tick();
        a_valid = 1'b0;
        b_valid = 1'b1;
        b_data = W'(12'h402);
        tick();
        a_valid = 1'b1;
        flush_req = 1'b1;
        settle();
        check("flush_a_ready", 256'(a_ready), 256'(0));
        check("flush_b_ready", 256'(b_ready), 256'(0));
        a_valid = 1'b0;
        b_valid = 1'b0;
        dl_hold = 1'b0;
        seen = 1'b0;
        ack_cyc = 0;
        for (int t = 0; t < 200; t++) begin
            tick();
            if (flush_ack) begin
                seen = 1'b1;
                ack_cyc = cyc;
                break;
            end
        end
        check("flush_ack_seen", 256'(seen), 256'(1));
        check("flush_ack_delay", 256'(ack_cyc - rise_cyc), 256'(DRAIN));
        check("flush_issued", 256'(issued_q.size()), 256'(2));
        if (issued_q.size() == 2) begin
            check("flush_span0", 256'(issued_q[0]), 256'(12'h401));
            check("flush_span1", 256'(issued_q[1]), 256'(12'h402));
        end
        a_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("flush_ack_hold", 256'(flush_ack), 256'(1));
            check("flush_blocked", 256'(a_ready), 256'(0));
        end
        a_valid = 1'b0;
        flush_req = 1'b0;
        settle();
        check("flush_ack_before_edge", 256'(flush_ack), 256'(1));
        tick();
        check("flush_ack_fall", 256'(flush_ack), 256'(0));
        check("flush_idle", 256'(busy), 256'(0));

        // ---------------- flush abort in DRAIN
        do_reset();
        flush_req = 1'b1;
        tick();                                   // enter DRAIN
        check("abort_busy", 256'(busy), 256'(1));
        check("abort_ack_c1", 256'(flush_ack), 256'(0));
        tick();                                   // DRAIN cycle 2
        flush_req = 1'b0;
        a_valid = 1'b1;
        a_data = W'(12'h501);
        settle();
        check("abort_still_blocked", 256'(a_ready), 256'(0));
        tick();                                   // abort to IDLE
        check("abort_ack", 256'(flush_ack), 256'(0));
        check("abort_intake", 256'(a_ready), 256'(1));
        a_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("abort_no_ack", 256'(flush_ack), 256'(0));
        end

        // ---------------- async reset mid-span
        do_reset();
        dl_lat = 20;
        a_valid = 1'b1;
        a_data = W'(12'h601);
        tick();
        a_data = W'(12'h602);
        tick();
        a_data = W'(12'h603);
        tick();
        a_valid = 1'b0;
        check("arst_cnt_pre", 256'(fifo_count), 256'(2));
        check("arst_data_pre", 256'(span_data), 256'(12'h601));
        tick();                                   // BUSY
        check("arst_busy_pre", 256'(busy), 256'(1));
        #2;
        rst = 1'b1;
        #1;
        check("arst_cnt", 256'(fifo_count), 256'(0));
        check("arst_start", 256'(span_start), 256'(0));
        check("arst_data", 256'(span_data), 256'(0));
        check("arst_busy", 256'(busy), 256'(0));
        tick();
        rst = 1'b0;
        a_valid = 1'b1;
        b_valid = 1'b1;
        settle();
        check("arst_a_first", 256'(a_ready), 256'(1));
        check("arst_b_wait", 256'(b_ready), 256'(0));
        tick();
        check("arst_b_next", 256'(b_ready), 256'(1));
        check("arst_a_next", 256'(a_ready), 256'(0));
        a_valid = 1'b0;
        b_valid = 1'b0;
        repeat (2) tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
